// File: rtl/cnt_seq_ctrl_pkg.sv
// Shared types and default constants for the stopwatch sequencer and its
// neighbouring counter/display blocks.
package cnt_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] DEF_TICK_DIV = 32'd100000;
    // Same terminal value the display block treats as its MAX.
    localparam logic [31:0] DEF_LIMIT    = 32'd99999999;

endpackage

// File: rtl/cnt_seq_ctrl_tick_gen.sv
// Programmable prescaler: counts enabled cycles 0..DIV-1 and flags the last
// one; holds when disabled so a paused period resumes where it left off.
module tick_gen
    import cnt_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] DIV   = DEF_TICK_DIV,
    parameter int          WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(DIV - 32'd1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt;

    assign tick = en && (cnt == TOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TOP) ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Stopwatch run/pause/lap sequencer: turns button pulses into counter
// enable/load controls and picks the live or lapped value for the display.
module cnt_seq_ctrl
    import cnt_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] TICK_DIV = DEF_TICK_DIV,
    parameter logic [31:0] LIMIT    = DEF_LIMIT,
    parameter int          WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_p,
    input  logic             stop_p,
    input  logic             clr_p,
    input  logic             lap_p,
    input  logic             load_p,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_ce,
    output logic             cnt_pe,
    output logic [WIDTH-1:0] cnt_d,
    output logic [WIDTH-1:0] dis_d,
    output logic             running,
    output logic             lap_on,
    output logic             done
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    state_t           state, state_nx;
    logic             ce_nx, pe_nx, lap_on_nx, lap_cap;
    logic             presc_en, presc_clr, tick;
    logic [WIDTH-1:0] d_nx, q_next, lap_reg;

    function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
        return (v >= LIM) ? LIM : v;
    endfunction

    // Value the counter holds once already-issued load/increment land; the
    // terminal decision uses it so an in-flight increment is never repeated.
    assign q_next = cnt_pe ? cnt_d : cnt_q + {{(WIDTH-1){1'b0}}, cnt_ce};

    tick_gen #(
        .DIV   (TICK_DIV),
        .WIDTH (WIDTH)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    always_comb begin
        state_nx  = state;
        ce_nx     = 1'b0;
        pe_nx     = 1'b0;
        d_nx      = '0;
        lap_on_nx = lap_on;
        lap_cap   = 1'b0;
        presc_en  = 1'b0;
        presc_clr = 1'b0;

        if (clr_p) begin
            pe_nx     = 1'b1;
            state_nx  = IDLE;
            presc_clr = 1'b1;
            lap_on_nx = 1'b0;
        end else if (load_p) begin
            pe_nx     = 1'b1;
            d_nx      = sat_load(load_val);
            state_nx  = (load_val >= LIM) ? DONE : IDLE;
            presc_clr = 1'b1;
            lap_on_nx = 1'b0;
        end else if (stop_p) begin
            if (state == RUN) state_nx = PAUSE;
        end else if (start_p) begin
            if (state == IDLE || state == PAUSE) state_nx = RUN;
        end else if (lap_p) begin
            if (state == RUN || state == PAUSE) begin
                lap_on_nx = !lap_on;
                lap_cap   = !lap_on;
            end
        end

        // Only a cycle that both starts and stays in RUN advances the prescaler.
        if (state == RUN && state_nx == RUN) begin
            if (q_next >= LIM) begin
                state_nx = DONE;
            end else begin
                presc_en = 1'b1;
                ce_nx    = tick;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt_ce  <= 1'b0;
            cnt_pe  <= 1'b0;
            cnt_d   <= '0;
            lap_on  <= 1'b0;
            lap_reg <= '0;
            dis_d   <= '0;
        end else begin
            state  <= state_nx;
            cnt_ce <= ce_nx;
            cnt_pe <= pe_nx;
            cnt_d  <= d_nx;
            lap_on <= lap_on_nx;
            if (clr_p) begin
                lap_reg <= '0;
            end else if (lap_cap) begin
                lap_reg <= cnt_q;
            end
            dis_d <= lap_on ? lap_reg : cnt_q;
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: directed scenarios plus a randomized run against a
// behavioural stopwatch model; two instances cover TICK_DIV=4 and TICK_DIV=1.
module tb_cnt_seq_ctrl;

    localparam logic [31:0] TD_A  = 32'd4;
    localparam logic [31:0] LIM_A = 32'd100;
    localparam logic [31:0] TD_B  = 32'd1;
    localparam logic [31:0] LIM_B = 32'd10;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_p, stop_p, clr_p, lap_p, load_p;
    logic [31:0] load_val;
    logic [31:0] qa, qb;

    logic        a_ce, a_pe, a_run, a_lap, a_done;
    logic [31:0] a_d, a_dis;
    logic        b_ce, b_pe, b_run, b_lap, b_done;
    logic [31:0] b_d, b_dis;

    int checks = 0;
    int errors = 0;

    // behavioural model state (instance A)
    int          m_mode, m_phase;
    logic        m_lap_on;
    logic [31:0] m_lap_val, m_total;
    logic        e_ce, e_pe, e_run, e_lap, e_done;
    logic [31:0] e_d, e_dis;

    always #5 clk = ~clk;

    cnt_seq_ctrl #(.TICK_DIV(TD_A), .LIMIT(LIM_A), .WIDTH(32)) u_a (
        .clk(clk), .rst(rst), .start_p(start_p), .stop_p(stop_p), .clr_p(clr_p),
        .lap_p(lap_p), .load_p(load_p), .load_val(load_val), .cnt_q(qa),
        .cnt_ce(a_ce), .cnt_pe(a_pe), .cnt_d(a_d), .dis_d(a_dis),
        .running(a_run), .lap_on(a_lap), .done(a_done)
    );

    cnt_seq_ctrl #(.TICK_DIV(TD_B), .LIMIT(LIM_B), .WIDTH(32)) u_b (
        .clk(clk), .rst(rst), .start_p(start_p), .stop_p(stop_p), .clr_p(clr_p),
        .lap_p(lap_p), .load_p(load_p), .load_val(load_val), .cnt_q(qb),
        .cnt_ce(b_ce), .cnt_pe(b_pe), .cnt_d(b_d), .dis_d(b_dis),
        .running(b_run), .lap_on(b_lap), .done(b_done)
    );

    // The counters the sequencer drives: load overrides increment.
    always @(posedge clk or posedge rst) begin
        if (rst)       qa <= 32'd0;
        else if (a_pe) qa <= a_d;
        else if (a_ce) qa <= qa + 32'd1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst)       qb <= 32'd0;
        else if (b_pe) qb <= b_d;
        else if (b_ce) qb <= qb + 32'd1;
    end

    task automatic pulse(input logic c, input logic ld, input logic sp,
                         input logic st, input logic lp, input logic [31:0] v);
        clr_p = c; load_p = ld; stop_p = sp; start_p = st; lap_p = lp; load_val = v;
        @(negedge clk);
        clr_p = 1'b0; load_p = 1'b0; stop_p = 1'b0; start_p = 1'b0; lap_p = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_p = 1'b0; stop_p = 1'b0; clr_p = 1'b0; lap_p = 1'b0; load_p = 1'b0;
        load_val = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_ce, a_pe, a_run, a_lap, a_done} !== 5'b0 || a_d !== 32'd0 || a_dis !== 32'd0) begin
            errors++;
            $display("FAIL reset_a ce=%b pe=%b d=%0d dis=%0d run=%b lap=%b done=%b, want all 0",
                     a_ce, a_pe, a_d, a_dis, a_run, a_lap, a_done);
        end
        checks++;
        if ({b_ce, b_pe, b_run, b_lap, b_done} !== 5'b0 || b_d !== 32'd0 || b_dis !== 32'd0) begin
            errors++;
            $display("FAIL reset_b ce=%b pe=%b d=%0d dis=%0d run=%b lap=%b done=%b, want all 0",
                     b_ce, b_pe, b_d, b_dis, b_run, b_lap, b_done);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_run !== 1'b0 || a_ce !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset run=%b ce=%b, want 0 0", a_run, a_ce);
        end
    endtask

    task automatic test_basic_run();
        pulse(0, 0, 0, 1, 0, 32'd0);
        checks++;
        if (a_run !== 1'b1) begin
            errors++;
            $display("FAIL run_entry running=%b, want 1", a_run);
        end
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            checks++;
            if (a_ce !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL run_ce cycle %0d got %b want %b", k, a_ce, (k % 4) == 0);
            end
        end
        checks++;
        if (qa !== 32'd3 || a_run !== 1'b1) begin
            errors++;
            $display("FAIL run_count cnt_q=%0d running=%b, want 3 1", qa, a_run);
        end
    endtask

    task automatic test_pause_resume();
        int          waitc = 0;
        int          seen  = 0;
        logic [31:0] q_hold;
        while (a_ce !== 1'b1 && waitc < 8) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (a_ce !== 1'b1) begin
            errors++;
            $display("FAIL pause_find_tick ce=%b after %0d cycles, want 1", a_ce, waitc);
        end
        repeat (2) @(negedge clk);
        pulse(0, 0, 1, 0, 0, 32'd0);
        checks++;
        if (a_run !== 1'b0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL pause_state running=%b done=%b, want 0 0", a_run, a_done);
        end
        q_hold = qa;
        repeat (50) begin
            @(negedge clk);
            if (a_ce === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || qa !== q_hold) begin
            errors++;
            $display("FAIL pause_hold ce_seen=%0d cnt_q=%0d, want 0 %0d", seen, qa, q_hold);
        end
        pulse(0, 0, 0, 1, 0, 32'd0);
        checks++;
        if (a_run !== 1'b1 || a_ce !== 1'b0) begin
            errors++;
            $display("FAIL resume_entry running=%b ce=%b, want 1 0", a_run, a_ce);
        end
        @(negedge clk);
        checks++;
        if (a_ce !== 1'b0) begin
            errors++;
            $display("FAIL resume_ce1 got %b want 0", a_ce);
        end
        @(negedge clk);
        checks++;
        if (a_ce !== 1'b1 || a_run !== 1'b1) begin
            errors++;
            $display("FAIL resume_ce2 ce=%b running=%b, want 1 1", a_ce, a_run);
        end
    endtask

    task automatic test_lap();
        int          waitc = 0;
        logic [31:0] q1;
        while (qa !== 32'd5 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (qa !== 32'd5) begin
            errors++;
            $display("FAIL lap_reach5 cnt_q=%0d, want 5", qa);
        end
        pulse(0, 0, 0, 0, 1, 32'd0);
        checks++;
        if (a_lap !== 1'b1 || a_dis !== 32'd5) begin
            errors++;
            $display("FAIL lap_on lap_on=%b dis=%0d, want 1 5", a_lap, a_dis);
        end
        waitc = 0;
        while (qa !== 32'd8 && waitc < 20) begin
            @(negedge clk);
            waitc++;
            checks++;
            if (a_dis !== 32'd5) begin
                errors++;
                $display("FAIL lap_frozen cnt_q=%0d dis=%0d, want 5", qa, a_dis);
            end
        end
        checks++;
        if (qa !== 32'd8) begin
            errors++;
            $display("FAIL lap_reach8 cnt_q=%0d, want 8", qa);
        end
        pulse(0, 0, 0, 0, 1, 32'd0);
        q1 = qa;
        checks++;
        if (a_lap !== 1'b0) begin
            errors++;
            $display("FAIL lap_off lap_on=%b, want 0", a_lap);
        end
        @(negedge clk);
        checks++;
        if (a_dis !== q1) begin
            errors++;
            $display("FAIL lap_follow dis=%0d, want %0d", a_dis, q1);
        end
    endtask

    task automatic test_simultaneous();
        int seen = 0;
        pulse(1, 0, 0, 1, 0, 32'd0);
        checks++;
        if (a_pe !== 1'b1 || a_d !== 32'd0 || a_ce !== 1'b0 || a_run !== 1'b0) begin
            errors++;
            $display("FAIL clr_start pe=%b d=%0d ce=%b run=%b, want 1 0 0 0", a_pe, a_d, a_ce, a_run);
        end
        @(negedge clk);
        checks++;
        if (a_pe !== 1'b0 || qa !== 32'd0 || a_run !== 1'b0) begin
            errors++;
            $display("FAIL clr_after pe=%b cnt_q=%0d run=%b, want 0 0 0", a_pe, qa, a_run);
        end
        pulse(0, 1, 0, 0, 0, 32'd200);
        checks++;
        if (a_pe !== 1'b1 || a_d !== 32'd100 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL load_sat pe=%b d=%0d done=%b, want 1 100 1", a_pe, a_d, a_done);
        end
        @(negedge clk);
        checks++;
        if (a_pe !== 1'b0 || qa !== 32'd100) begin
            errors++;
            $display("FAIL load_sat_after pe=%b cnt_q=%0d, want 0 100", a_pe, qa);
        end
        pulse(0, 0, 0, 1, 0, 32'd0);
        repeat (5) begin
            @(negedge clk);
            if (a_ce === 1'b1 || a_done !== 1'b1 || a_run !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL done_ignores_start bad_cycles=%0d, want 0", seen);
        end
        pulse(0, 1, 0, 0, 0, 32'd99);
        checks++;
        if (a_d !== 32'd99 || a_done !== 1'b0 || a_run !== 1'b0) begin
            errors++;
            $display("FAIL load_99 d=%0d done=%b run=%b, want 99 0 0", a_d, a_done, a_run);
        end
        pulse(0, 1, 0, 0, 0, 32'd100);
        checks++;
        if (a_d !== 32'd100 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL load_100 d=%0d done=%b, want 100 1", a_d, a_done);
        end
        pulse(1, 0, 0, 0, 0, 32'd0);
        checks++;
        if (a_pe !== 1'b1 || a_d !== 32'd0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL clr_from_done pe=%b d=%0d done=%b, want 1 0 0", a_pe, a_d, a_done);
        end
        @(negedge clk);
        pulse(0, 0, 0, 0, 1, 32'd0);
        checks++;
        if (a_lap !== 1'b0) begin
            errors++;
            $display("FAIL lap_in_idle lap_on=%b, want 0", a_lap);
        end
    endtask

    task automatic test_terminal();
        int          n = 0, nce = 0, viol = 0, seen = 0;
        logic [31:0] qmax = 32'd0;
        pulse(1, 0, 0, 0, 0, 32'd0);
        @(negedge clk);
        pulse(0, 0, 0, 1, 0, 32'd0);
        while (b_done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
            if (b_ce === 1'b1) nce++;
            if (b_ce === 1'b1 && b_run !== 1'b1) viol++;
            if (qb > qmax) qmax = qb;
        end
        checks++;
        if (b_done !== 1'b1 || b_ce !== 1'b0 || b_run !== 1'b0) begin
            errors++;
            $display("FAIL term_done done=%b ce=%b run=%b, want 1 0 0", b_done, b_ce, b_run);
        end
        checks++;
        if (nce != 10 || qb !== 32'd10 || qmax > 32'd10) begin
            errors++;
            $display("FAIL term_count ce_pulses=%0d cnt_q=%0d max=%0d, want 10 10 10", nce, qb, qmax);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL term_ce_outside_run count=%0d, want 0", viol);
        end
        pulse(0, 0, 0, 1, 0, 32'd0);
        repeat (5) begin
            @(negedge clk);
            if (b_done !== 1'b1 || b_ce === 1'b1 || qb !== 32'd10) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL term_start_ignored bad_cycles=%0d, want 0", seen);
        end
    endtask

    task automatic test_async_reset();
        int seen = 0;
        pulse(1, 0, 0, 0, 0, 32'd0);
        pulse(0, 0, 0, 1, 0, 32'd0);
        repeat (6) @(negedge clk);
        pulse(0, 0, 0, 0, 1, 32'd0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_ce, a_pe, a_run, a_lap, a_done} !== 5'b0 || a_d !== 32'd0 || a_dis !== 32'd0) begin
            errors++;
            $display("FAIL async_reset ce=%b pe=%b d=%0d dis=%0d run=%b lap=%b done=%b, want all 0",
                     a_ce, a_pe, a_d, a_dis, a_run, a_lap, a_done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (a_ce === 1'b1 || a_run !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL post_reset_idle bad_cycles=%0d, want 0", seen);
        end
        pulse(0, 0, 0, 1, 0, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (a_ce !== (k == 4)) begin
                errors++;
                $display("FAIL post_reset_run cycle %0d ce=%b want %b", k, a_ce, k == 4);
            end
        end
    endtask

    // One clock of the stopwatch rules, from the current pulses and count.
    task automatic model_step();
        logic        run_now;
        logic [31:0] v;
        e_ce  = 1'b0;
        e_pe  = 1'b0;
        e_d   = 32'd0;
        e_dis = m_lap_on ? m_lap_val : qa;
        if (clr_p) begin
            e_pe = 1'b1; m_mode = M_IDLE; m_phase = 0;
            m_lap_on = 1'b0; m_lap_val = 32'd0; m_total = 32'd0;
        end else if (load_p) begin
            v = (load_val >= LIM_A) ? LIM_A : load_val;
            e_pe = 1'b1; e_d = v; m_total = v; m_phase = 0; m_lap_on = 1'b0;
            m_mode = (load_val >= LIM_A) ? M_DONE : M_IDLE;
        end else begin
            run_now = (m_mode == M_RUN) && !stop_p;
            if (stop_p) begin
                if (m_mode == M_RUN) m_mode = M_PAUSE;
            end else if (start_p) begin
                if (m_mode == M_IDLE || m_mode == M_PAUSE) m_mode = M_RUN;
            end else if (lap_p && (m_mode == M_RUN || m_mode == M_PAUSE)) begin
                if (!m_lap_on) m_lap_val = qa;
                m_lap_on = !m_lap_on;
            end
            if (run_now) begin
                if (m_total >= LIM_A) begin
                    m_mode = M_DONE;
                end else if (m_phase == int'(TD_A) - 1) begin
                    e_ce = 1'b1; m_total = m_total + 32'd1; m_phase = 0;
                end else begin
                    m_phase++;
                end
            end
        end
        e_run  = (m_mode == M_RUN);
        e_done = (m_mode == M_DONE);
        e_lap  = m_lap_on;
    endtask

    task automatic test_random();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_mode = M_IDLE; m_phase = 0; m_lap_on = 1'b0; m_lap_val = 32'd0; m_total = 32'd0;
        e_ce = 1'b0; e_pe = 1'b0; e_d = 32'd0; e_dis = 32'd0;
        e_run = 1'b0; e_lap = 1'b0; e_done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            checks++;
            if (a_ce !== e_ce) begin
                errors++; $display("FAIL rnd_ce cyc %0d got %b want %b", i, a_ce, e_ce);
            end
            checks++;
            if (a_pe !== e_pe) begin
                errors++; $display("FAIL rnd_pe cyc %0d got %b want %b", i, a_pe, e_pe);
            end
            checks++;
            if (a_d !== e_d) begin
                errors++; $display("FAIL rnd_d cyc %0d got %0d want %0d", i, a_d, e_d);
            end
            checks++;
            if (a_dis !== e_dis) begin
                errors++; $display("FAIL rnd_dis cyc %0d got %0d want %0d", i, a_dis, e_dis);
            end
            checks++;
            if (a_run !== e_run) begin
                errors++; $display("FAIL rnd_running cyc %0d got %b want %b", i, a_run, e_run);
            end
            checks++;
            if (a_lap !== e_lap) begin
                errors++; $display("FAIL rnd_lap_on cyc %0d got %b want %b", i, a_lap, e_lap);
            end
            checks++;
            if (a_done !== e_done) begin
                errors++; $display("FAIL rnd_done cyc %0d got %b want %b", i, a_done, e_done);
            end
            clr_p   = ($urandom_range(0, 63) == 0);
            load_p  = ($urandom_range(0, 39) == 0);
            stop_p  = ($urandom_range(0, 11) == 0);
            start_p = ($urandom_range(0, 5) == 0);
            lap_p   = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = 32'($urandom_range(100, 200));
                1:       load_val = 32'($urandom_range(90, 99));
                default: load_val = 32'($urandom_range(0, 99));
            endcase
            model_step();
            @(negedge clk);
        end
        clr_p = 1'b0; load_p = 1'b0; stop_p = 1'b0; start_p = 1'b0; lap_p = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_pause_resume();
        test_lap();
        test_simultaneous();
        test_terminal();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
- Run/pause/lap sequencer for the debounced-counter-display datapath, i.e. stopwatch control.
- Takes one-cycle command pulses from the button front end (debounce plus edge detect) and generates the counter's enable, load and data inputs from a programmable tick prescaler.
- Selects what the seven-segment display shows: live count or a latched lap value.
- Sits between the button pulse stage and the counter/display pair.

Parameters:
- TICK_DIV, 32'd100000: clk cycles per counter increment while running; legal range ≥ 1.
- LIMIT, 32'd99999999: terminal count; reaching it stops the run.
- WIDTH, 32: counter/display data width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start_p  in  1  start/resume command pulse
- stop_p  in  1  pause command pulse
- clr_p  in  1  clear command pulse
- lap_p  in  1  lap toggle pulse
- load_p  in  1  preset command pulse
- load_val  in  WIDTH  preset value
- cnt_q  in  WIDTH  counter current value
- cnt_ce  out  1  counter increment enable
- cnt_pe  out  1  counter synchronous load
- cnt_d  out  WIDTH  counter load data
- dis_d  out  WIDTH  value to display
- running  out  1  high in RUN
- lap_on  out  1  display frozen on lap value
- done  out  1  high in DONE

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; prescaler 0; lap register 0.
- Counter contract: on cnt_pe, q becomes cnt_d next edge; otherwise on cnt_ce, q becomes q+1. cnt_pe overrides cnt_ce.
- States:
  - IDLE: start_p goes to RUN.
  - RUN: start_p is ignored; stop_p goes to PAUSE. A tick with cnt_q == LIMIT-1 issues the final cnt_ce and goes to DONE.
  - PAUSE: start_p goes to RUN; stop_p is ignored.
  - DONE: start_p is ignored; only clr_p or load_p leave DONE.
- Priority of same-cycle pulses: clr_p > load_p > stop_p > start_p > lap_p. Only the highest-priority command acts; the others are dropped.
- clr_p, any state: cnt_pe=1, cnt_d=0 for exactly one cycle; go to IDLE; clear prescaler, lap_on and the lap register.
- load_p, any state:
  - If load_val ≥ LIMIT: cnt_d=LIMIT, go to DONE.
  - Otherwise: cnt_d=load_val for one cycle, go to IDLE.
  - In both cases clear the prescaler and lap_on.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; holds its value in PAUSE, so resume continues the partial period.
  - tick is asserted when prescaler == TICK_DIV-1 in RUN.
  - cnt_ce = tick, registered: the first cnt_ce comes TICK_DIV cycles after the RUN entry edge, then every TICK_DIV cycles.
  - TICK_DIV=1 gives cnt_ce high on every RUN cycle.
- cnt_ce is never asserted outside RUN, nor in the same cycle as cnt_pe.
- Lap:
  - lap_p in RUN or PAUSE toggles lap_on. On the 0→1 toggle, the lap register captures cnt_q.
  - lap_p in IDLE or DONE is ignored.
- Display: dis_d = lap_on ? lap register : cnt_q. Registered, 1-cycle latency.
- All other outputs are registered. running and done decode the state register.
- No arithmetic overflow: the counter never exceeds LIMIT under this controller.

Decomposition:
- Shared package holds:
  - state enum: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3
  - default TICK_DIV and LIMIT constants, shared with the display block's MAX convention
- One sub-module, tick_gen (WIDTH-bit prescaler with enable and synchronous clear, outputs a tick pulse).
- FSM, lap register and display mux stay in the top.

Test Plan:
- Basic run, TICK_DIV=4, LIMIT=100: reset, then start_p → cnt_ce pulses at cycles 4, 8 and 12 after entry; cnt_q reaches 3 at cycle 13; running=1.
- Pause/resume with partial period: stop_p 2 cycles after a tick, wait 50 cycles → no cnt_ce. Then start_p → next cnt_ce 2 cycles later; state is RUN.
- Terminal count, LIMIT=10, TICK_DIV=1: start_p → cnt_q counts 0..9, then state DONE, done=1, cnt_ce=0. Further start_p has no effect.
- Lap: lap_p while cnt_q=5 → dis_d holds 5 while cnt_q advances to 8; lap_p again → dis_d follows cnt_q on the next cycle.
- Simultaneous commands: clr_p+start_p in RUN → cnt_pe=1, cnt_d=0 for one cycle, state IDLE. load_p with load_val=200 and LIMIT=100 → cnt_d=100, done=1.
- Asynchronous reset mid-run: assert rst between edges → all outputs 0 immediately. Release → IDLE, no cnt_ce until start_p.
